// File: rtl/mult_pkg.sv
// Shared types, default sizing and helpers for the shared multiplier scheduler.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_N_REQ = 4;
    localparam int DEF_WIDTH = 4;

    function automatic int id_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/shift_add_core.sv
// Sequential unsigned shift-add multiplier, one multiplier bit per cycle.
// Latency: done pulses during the WIDTH-th cycle after start; product valid the cycle after.
// Backpressure: none; product holds until the next start, so the owner may stall freely.
module shift_add_core
    import mult_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0]   a_sh;
    logic [2*WIDTH-1:0] b_sh;
    logic [2*WIDTH-1:0] acc;
    logic [CNT_W-1:0]   cnt;
    logic               running;

    // a_sh[0] is multiplier bit cnt and b_sh is b << cnt, so no variable bit select is needed.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh    <= '0;
            b_sh    <= '0;
            acc     <= '0;
            cnt     <= '0;
            running <= 1'b0;
        end else if (start) begin
            a_sh    <= a;
            b_sh    <= {{WIDTH{1'b0}}, b};
            acc     <= '0;
            cnt     <= '0;
            running <= 1'b1;
        end else if (running) begin
            if (a_sh[0]) begin
                acc <= acc + b_sh;
            end
            a_sh <= a_sh >> 1;
            b_sh <= b_sh << 1;
            cnt  <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(WIDTH - 1)) begin
                running <= 1'b0;
            end
        end
    end

    assign done    = running && (cnt == CNT_W'(WIDTH - 1));
    assign product = acc;

endmodule

// File: rtl/mult_sched.sv
// Round-robin scheduler sharing one shift-add multiplier among N_REQ requesters.
// Latency: handshake in cycle T gives rsp_valid in cycle T+WIDTH+1; issue interval WIDTH+2.
// Backpressure: rsp_ready low holds the response and keeps every req_ready low.
module mult_sched
    import mult_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int WIDTH = DEF_WIDTH,
    parameter int ID_W  = id_width(N_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req_valid,
    output logic [N_REQ-1:0]         req_ready,
    input  logic [N_REQ*WIDTH-1:0]   req_a,
    input  logic [N_REQ*WIDTH-1:0]   req_b,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
    output logic [2*WIDTH-1:0]       rsp_product
);

    state_t              state;
    logic [ID_W-1:0]     rr_ptr;
    logic [ID_W-1:0]     rr_next;
    logic [ID_W-1:0]     gnt_idx;
    logic [ID_W-1:0]     scan_idx;
    logic [ID_W-1:0]     job_id;
    logic                gnt_vld;
    logic                start;
    logic                core_done;
    logic [WIDTH-1:0]    op_a;
    logic [WIDTH-1:0]    op_b;
    logic [2*WIDTH-1:0]  core_product;

    // Scan downward so the requester closest to rr_ptr is the last (winning) assignment.
    always_comb begin
        gnt_vld  = 1'b0;
        gnt_idx  = '0;
        scan_idx = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            scan_idx = ID_W'((int'(rr_ptr) + k) % N_REQ);
            if (req_valid[scan_idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = scan_idx;
            end
        end
    end

    assign rr_next = (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
    assign start   = (state == IDLE) && gnt_vld && !rst;
    assign op_a    = req_a[gnt_idx*WIDTH +: WIDTH];
    assign op_b    = req_b[gnt_idx*WIDTH +: WIDTH];

    always_comb begin
        req_ready = '0;
        if (start) begin
            req_ready = N_REQ'(1) << gnt_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            job_id    <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_vld) begin
                        job_id <= gnt_idx;
                        rr_ptr <= rr_next;
                        state  <= BUSY;
                    end
                end
                BUSY: begin
                    if (core_done) begin
                        rsp_valid <= 1'b1;
                        rsp_id    <= job_id;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The core accumulator is only rewritten on start, which cannot occur in DONE,
    // so it already serves as the held response product.
    assign rsp_product = core_product;

    shift_add_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (op_a),
        .b       (op_b),
        .done    (core_done),
        .product (core_product)
    );

endmodule

// File: tb/tb_mult_sched.sv
// Bench for mult_sched: vector table, round-robin scoreboard and directed corner sequences.
module tb_mult_sched;

    localparam int N = 4;
    localparam int W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [N*W-1:0]   req_a;
    logic [N*W-1:0]   req_b;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [1:0]       rsp_id;
    logic [2*W-1:0]   rsp_product;

    mult_sched #(.N_REQ(N), .WIDTH(W), .ID_W(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_product (rsp_product)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int id;
        int prod;
    } exp_t;

    typedef struct {
        int id;
        int a;
        int b;
        int prod;
    } vec_t;

    exp_t sb[$];
    int   m_rr = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard: predict each grant from the bench's own round-robin pointer,
    // push the expected product, and compare at every response handshake.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            m_rr = 0;
            check("ready_during_reset", int'(req_ready), 0);
        end else begin
            if (req_ready != '0) begin
                int g;
                g = -1;
                for (int k = N - 1; k >= 0; k--) begin
                    if (req_valid[(m_rr + k) % N]) g = (m_rr + k) % N;
                end
                check("grant_onehot", int'(req_ready), (g < 0) ? -1 : (1 << g));
                if (g >= 0) begin
                    sb.push_back('{g, int'(req_a[g*W +: W]) * int'(req_b[g*W +: W])});
                    m_rr = (g + 1) % N;
                end
            end
            if (rsp_valid && rsp_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp: got id %0d product %0d, expected no response",
                             rsp_id, rsp_product);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("sb_rsp_id", int'(rsp_id), e.id);
                    check("sb_rsp_product", int'(rsp_product), e.prod);
                end
            end
        end
    end

    task automatic set_req(input int i, input int a, input int b);
        req_a[i*W +: W] = W'(a);
        req_b[i*W +: W] = W'(b);
        req_valid[i]    = 1'b1;
    endtask

    // Returns at the negedge of the first cycle with any req_ready bit high.
    task automatic wait_grant(input string name, output int g, output int c);
        bit found;
        found = 0;
        g = -1;
        c = 0;
        for (int n = 0; n < 60 && !found; n++) begin
            @(negedge clk);
            if (req_ready != '0) begin
                found = 1;
                c = cyc;
                for (int k = 0; k < N; k++) if (req_ready[k]) g = k;
            end
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL %s: got no grant within 60 cycles, expected a grant", name);
        end
    endtask

    // Returns at the negedge of the first cycle with rsp_valid high.
    task automatic wait_rsp(input string name, output int c);
        bit found;
        found = 0;
        c = 0;
        for (int n = 0; n < 60 && !found; n++) begin
            @(negedge clk);
            if (rsp_valid) begin
                found = 1;
                c = cyc;
            end
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL %s: got no rsp_valid within 60 cycles, expected a response", name);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    vec_t tbl[8];
    int   ord[4];

    initial begin
        int g, t, t2, c, c_hs;
        bit saw;

        tbl[0] = '{1, 13, 11, 143};
        tbl[1] = '{0, 15, 15, 225};
        tbl[2] = '{0,  0,  9,   0};
        tbl[3] = '{2,  1, 15,  15};
        tbl[4] = '{3,  8,  8,  64};
        tbl[5] = '{1, 15,  0,   0};
        tbl[6] = '{2,  7,  6,  42};
        tbl[7] = '{3,  5,  3,  15};
        ord    = '{3, 0, 1, 2};

        rst = 1'b1;
        req_valid = '0;
        req_a = '0;
        req_b = '0;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_rsp_valid", int'(rsp_valid), 0);
        check("reset_rsp_id", int'(rsp_id), 0);
        check("reset_rsp_product", int'(rsp_product), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Single-requester vectors; operands are scrambled right after the handshake.
        for (int i = 0; i < 8; i++) begin
            set_req(tbl[i].id, tbl[i].a, tbl[i].b);
            @(negedge clk);
            check("vec_ready_same_cycle", int'(req_ready), 1 << tbl[i].id);
            t = cyc;
            @(posedge clk); #1;
            req_valid = '0;
            req_a = 16'($urandom);
            req_b = 16'($urandom);
            wait_rsp("vec_rsp", c);
            check("vec_latency", c - t, W + 1);
            check("vec_product", int'(rsp_product), tbl[i].prod);
            check("vec_id", int'(rsp_id), tbl[i].id);
            @(posedge clk); #1;
        end

        // Requesters 0 and 2 together straight out of reset.
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        set_req(0, 3, 4);
        set_req(2, 6, 7);
        wait_grant("s2_first", g, t);
        check("s2_first_grant", g, 0);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        wait_grant("s2_second", g, t2);
        check("s2_second_grant", g, 2);
        check("s2_interval", t2 - t, W + 2);
        @(posedge clk); #1;
        req_valid[2] = 1'b0;

        // All four held valid: rotation continues from requester 3.
        for (int i = 0; i < N; i++) set_req(i, i + 3, i + 9);
        for (int k = 0; k < N; k++) begin
            wait_grant("s3_grant", g, t);
            check("s3_order", g, ord[k]);
            @(posedge clk); #1;
        end
        req_valid = '0;
        wait_rsp("s3_last_rsp", c);
        @(posedge clk); #1;

        // Backpressure with another requester pending.
        rsp_ready = 1'b0;
        set_req(1, 9, 7);
        wait_grant("bp_grant", g, t);
        check("bp_grant_id", g, 1);
        @(posedge clk); #1;
        req_valid = '0;
        set_req(3, 2, 3);
        wait_rsp("bp_rsp", c);
        check("bp_latency", c - t, W + 1);
        repeat (3) begin
            @(negedge clk);
            check("bp_valid_held", int'(rsp_valid), 1);
            check("bp_product_held", int'(rsp_product), 63);
            check("bp_id_held", int'(rsp_id), 1);
            check("bp_ready_blocked", int'(req_ready), 0);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        c_hs = cyc;
        wait_grant("bp_next_grant", g, t);
        check("bp_next_id", g, 3);
        check("bp_next_gap", t - c_hs, 1);
        @(posedge clk); #1;
        req_valid = '0;
        wait_rsp("bp_next_rsp", c);
        check("bp_next_product", int'(rsp_product), 6);
        @(posedge clk); #1;

        // Reset in the second BUSY cycle abandons the job and restores rr pointer to 0.
        set_req(2, 5, 5);
        wait_grant("rst_grant", g, t);
        check("rst_grant_id", g, 2);
        @(posedge clk); #1;
        req_valid = '0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        saw = 0;
        repeat (10) begin
            @(negedge clk);
            if (rsp_valid) saw = 1;
        end
        check("rst_no_rsp", int'(saw), 0);
        @(posedge clk); #1;
        set_req(3, 1, 1);
        set_req(0, 4, 5);
        wait_grant("post_rst_grant", g, t);
        check("post_rst_rr_zero", g, 0);
        @(posedge clk); #1;
        req_valid = '0;
        wait_rsp("post_rst_rsp", c);
        check("post_rst_latency", c - t, W + 1);
        check("post_rst_product", int'(rsp_product), 20);
        check("post_rst_id", int'(rsp_id), 0);
        @(posedge clk); #1;
        repeat (2) @(posedge clk);

        check("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mult_sched.md
Name: mult_sched

Overview:
Shares one sequential shift-add multiplier engine between N_REQ requesters.
- Round-robin arbitration selects the next requester.
- A valid/ready handshake accepts operands, then the engine runs one multiplier bit per cycle.
- The product is returned on a single response channel, tagged with the requester ID.
- Sits between requesting datapath blocks and the multiply resource, replacing ad-hoc per-requester multipliers.

Parameters:
N_REQ, 4, number of requesters (>=2)
WIDTH, 4, operand width in bits; product is 2*WIDTH
ID_W, $clog2(N_REQ), width of the response ID

Ports:
clk  in  1  single clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
req_valid  in  N_REQ  per-requester request valid
req_ready  out  N_REQ  per-requester accept; at most one bit high
req_a  in  N_REQ*WIDTH  multiplier operands, requester i at [i*WIDTH +: WIDTH]
req_b  in  N_REQ*WIDTH  multiplicand operands, same packing
rsp_valid  out  1  product available
rsp_ready  in  1  consumer accepts product
rsp_id  out  ID_W  index of requester that owns rsp_product
rsp_product  out  2*WIDTH  unsigned product a*b

Behaviour:
- Reset (rst high at a rising edge):
  - State IDLE, rr pointer = 0 (requester 0 highest priority).
  - rsp_valid=0, rsp_id=0, rsp_product=0, accumulator and counter 0.
  - req_ready is all-zero while rst is high.
  - Reset mid-operation abandons the job; no response is ever produced for it.
- State IDLE:
  - Grant g = first i with req_valid[i], searching from rr pointer upward with wrap-around.
  - req_ready[g]=1 combinationally; all other bits 0. If no req_valid, all 0.
  - Handshake edge (req_valid[g] & req_ready[g]):
    - Latch a=req_a[g], b=req_b[g] zero-extended to 2*WIDTH, id=g.
    - Clear accumulator and counter.
    - rr pointer <= (g+1) mod N_REQ; go to BUSY.
- State BUSY:
  - req_ready all 0.
  - Each edge: if a[count], acc <= acc + (b << count); count <= count+1.
  - After exactly WIDTH BUSY edges, go to DONE.
  - All WIDTH cycles are run regardless of operand values; there is no early exit for zero operands.
- State DONE:
  - rsp_valid=1; rsp_product=acc and rsp_id=id are held stable while rsp_valid is high.
  - req_ready all 0.
  - Edge with rsp_ready=1: rsp_valid <= 0, go to IDLE.
  - rsp_ready=0: hold indefinitely (backpressure).
- Latency:
  - If the handshake occurs in cycle T, rsp_valid is first high in cycle T+WIDTH+1.
  - Next grant is possible at the earliest in the cycle after the response handshake.
  - Minimum issue interval is therefore WIDTH+2 cycles.
- Width rules:
  - Unsigned only. Accumulator is 2*WIDTH bits; (2^WIDTH-1)^2 fits, so no overflow is possible.
  - Counter is wide enough to hold WIDTH without wrap.
- Requester rules:
  - A requester may drop or change req_valid and operands while not granted.
  - Operands are sampled only on the handshake edge; later changes have no effect on the job.
- Simultaneous events:
  - Multiple req_valid in IDLE: exactly one is granted, per the rr pointer.
  - rsp_ready high outside DONE is ignored.

Decomposition:
- Package mult_pkg:
  - State enum {IDLE, BUSY, DONE}.
  - Default N_REQ/WIDTH constants.
  - ID-width helper function.
- Sub-module shift_add_core:
  - Holds operand registers, accumulator and bit counter.
  - Inputs: start, a, b. Outputs: done pulse, product.
- mult_sched itself holds the round-robin arbiter, the FSM and the response register.

Test Plan:
- Single request, requester 1: a=13, b=11 (WIDTH=4) -> req_ready[1] in the same cycle; rsp_valid at T+5; rsp_product=143 (0x8F), rsp_id=1.
- req_valid[0] and req_valid[2] raised together from reset, rsp_ready=1 -> grants in order 0 then 2; second handshake 6 cycles after the first; rsp_id 0 then 2.
- Continuing from the previous scenario, all four requesters held valid -> grant order 3,0,1,2; never two req_ready bits high.
- Boundaries, requester 0: a=15, b=15 -> 225 (0xE1); a=0, b=9 -> 0, with rsp_valid still at T+5.
- Backpressure: rsp_ready held low 3 cycles in DONE -> rsp_valid, rsp_product and rsp_id stable; req_ready all 0 despite pending req_valid; product accepted when rsp_ready rises.
- Reset mid-operation: rst pulsed in the 2nd BUSY cycle -> rsp_valid never asserts for that job; rr pointer=0; a new request from requester 0 completes normally.
